// File: rtl/e191_log_pkg.sv
// Shared types and field layout for the output-vector event logger.
package e191_log_pkg;
  localparam int Y_W    = 11;
  localparam int Y_LSB  = 0;
  localparam int TS_LSB = Y_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;
endpackage

// File: rtl/e191_log_fifo.sv
// Logger FIFO: synchronous write, registered head output, occupancy tracking.
module e191_log_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic                     rd_valid,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [LW-1:0] level_n;
  logic          push_ok, pop_ok;

  assign rd_valid = (level != '0);
  assign full     = (level == LW'(DEPTH));
  assign pop_ok   = pop & rd_valid;
  assign push_ok  = push & (~full | pop_ok);
  assign rd_ptr_n = rd_ptr + AW'(pop_ok);
  assign level_n  = level + LW'(push_ok) - LW'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      // The next head is the slot being written when the queue was otherwise empty.
      if (level_n != '0)
        rd_data <= (push_ok && (wr_ptr == rd_ptr_n)) ? wdata : mem[rd_ptr_n];
    end
  end
endmodule

// File: rtl/e191_out_logger.sv
// Captures changes of the upstream FSM output vector with a timestamp into a FIFO.
module e191_out_logger
  import e191_log_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TS_W        = 16,
  parameter int STOP_ON_OVF = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [Y_W-1:0]          y_in,
  input  logic                    en,
  input  logic                    clr_ovf,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [TS_W+Y_W-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [7:0]              drop_cnt
);
  localparam int DW = TS_W + Y_W;

  state_e          state, state_n;
  logic [TS_W-1:0] ts;
  logic [Y_W-1:0]  y_prev;
  logic [DW-1:0]   wdata;
  logic            evt, pop, full, drop, push;

  assign pop  = rd_valid & rd_ready;
  assign evt  = (state == RUN) && (y_in != '0) && (y_in != y_prev);
  assign drop = evt & full & ~pop;
  assign push = evt & ~drop;

  always_comb begin
    wdata                    = '0;
    wdata[TS_LSB +: TS_W]    = ts;
    wdata[Y_LSB  +: Y_W]     = y_in;
  end

  e191_log_fifo #(.DEPTH(DEPTH), .W(DW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wdata    (wdata),
    .pop      (pop),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (level),
    .full     (full)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (en) state_n = RUN;
      RUN: begin
        if (drop && (STOP_ON_OVF != 0)) state_n = HALT;
        else if (!en)                   state_n = IDLE;
      end
      HALT:    if (clr_ovf) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ts     <= '0;
      y_prev <= '0;
    end else begin
      state  <= state_n;
      ts     <= ts + 1'b1;
      y_prev <= y_in;
    end
  end

  // A drop in the clearing cycle still counts, so the clear never hides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= {7'd0, drop};
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_e191_out_logger.sv
// Three logger configurations driven by shared stimulus, each checked against a queue model.
module tb_e191_out_logger;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, clr_ovf = 1'b0, rd_ready = 1'b0;
  logic [10:0] y_in = '0;
  int          n_chk = 0, n_pass = 0, cyc = 0;
  bit          go = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc = 0;
    else     cyc++;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  // Instance 0: defaults; 1: halt on overflow; 2: 4-bit timestamp.
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int D  = 8;
    localparam int TW = (g == 2) ? 4 : 16;
    localparam int S  = (g == 1) ? 1 : 0;
    localparam int LW = $clog2(D) + 1;

    logic          rdv, ovf;
    logic [TW+10:0] rdd;
    logic [LW-1:0] lvl;
    logic [7:0]    dc;

    e191_out_logger #(.DEPTH(D), .TS_W(TW), .STOP_ON_OVF(S)) dut (
      .clk(clk), .rst(rst), .y_in(y_in), .en(en), .clr_ovf(clr_ovf),
      .rd_valid(rdv), .rd_ready(rd_ready), .rd_data(rdd), .level(lvl),
      .overflow(ovf), .drop_cnt(dc)
    );

    longint q[$];
    int     mts, myp, mdc;
    bit     mrun, mhalt, movf;

    always @(posedge clk) begin
      bit pop, ev, drop;
      if (rst) begin
        q.delete(); mts = 0; myp = 0; mrun = 0; mhalt = 0; movf = 0; mdc = 0;
      end else begin
        pop  = (q.size() != 0) && rd_ready;
        ev   = mrun && (y_in != 0) && (int'(y_in) != myp);
        drop = ev && (q.size() == D) && !pop;
        if (pop) void'(q.pop_front());
        if (ev && !drop) q.push_back(longint'(mts) * 2048 + longint'(y_in));
        if (clr_ovf) begin
          movf = drop; mdc = drop ? 1 : 0;
        end else if (drop) begin
          movf = 1;
          if (mdc < 255) mdc++;
        end
        if (mrun) begin
          if (drop && S != 0) begin mrun = 0; mhalt = 1; end
          else if (!en) mrun = 0;
        end else if (mhalt) begin
          if (clr_ovf) mhalt = 0;
        end else if (en) mrun = 1;
        myp = int'(y_in);
        mts = (mts + 1) % (1 << TW);
      end
    end

    always @(negedge clk) begin
      if (go) begin
        chk($sformatf("i%0d rd_valid", g), longint'(rdv), longint'(q.size() != 0));
        chk($sformatf("i%0d level", g), longint'(lvl), longint'(q.size()));
        chk($sformatf("i%0d overflow", g), longint'(ovf), longint'(movf));
        chk($sformatf("i%0d drop_cnt", g), longint'(dc), longint'(mdc));
        if (q.size() != 0) chk($sformatf("i%0d rd_data", g), longint'(rdd), q[0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int     exp_rb[8];
    longint t0;
    exp_rb = '{2, 3, 4, 5, 6, 7, 8, 'h400};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rd_valid", longint'(inst[0].rdv), 0);
    chk("reset level", longint'(inst[0].lvl), 0);
    chk("reset overflow", longint'(inst[0].ovf), 0);
    chk("reset drop_cnt", longint'(inst[0].dc), 0);
    chk("reset rd_data", longint'(inst[0].rdd), 0);
    rst = 1'b0; go = 1'b1; en = 1'b1; y_in = '0;

    // Basic capture: only real changes to non-zero vectors are logged.
    @(negedge clk); y_in = 11'h200;
    @(negedge clk); y_in = 11'h200;
    @(negedge clk); y_in = 11'h080;
    @(negedge clk); y_in = 11'h000;
    @(negedge clk);
    chk("basic level", longint'(inst[0].lvl), 2);
    chk("basic first y", longint'(inst[0].rdd[10:0]), 'h200);
    t0 = longint'(inst[0].rdd[26:11]);
    rd_ready = 1'b1;
    @(negedge clk); rd_ready = 1'b0;
    chk("basic second y", longint'(inst[0].rdd[10:0]), 'h080);
    chk("basic ts delta", longint'(inst[0].rdd[26:11]) - t0, 2);
    rd_ready = 1'b1;
    @(negedge clk); rd_ready = 1'b0;
    chk("basic drained", longint'(inst[0].lvl), 0);

    // Overflow: ten distinct events into an eight-deep queue.
    for (int i = 1; i <= 10; i++) begin
      y_in = 11'(i);
      @(negedge clk);
    end
    y_in = '0;
    chk("ovf level", longint'(inst[0].lvl), 8);
    chk("ovf flag", longint'(inst[0].ovf), 1);
    chk("ovf drop_cnt", longint'(inst[0].dc), 2);
    chk("ovf head", longint'(inst[0].rdd[10:0]), 1);
    chk("halt drop_cnt", longint'(inst[1].dc), 1);
    chk("halt state", longint'(inst[1].dut.state), 2);

    // Full with simultaneous pop and event.
    @(negedge clk); y_in = 11'h400; rd_ready = 1'b1;
    @(negedge clk); y_in = '0; rd_ready = 1'b0;
    chk("simul level", longint'(inst[0].lvl), 8);
    chk("simul drop_cnt", longint'(inst[0].dc), 2);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("readback %0d", k), longint'(inst[0].rdd[10:0]), longint'(exp_rb[k]));
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk("readback empty", longint'(inst[0].lvl), 0);

    // Halted logger ignores events until cleared, then resumes.
    y_in = 11'h011;
    @(negedge clk); y_in = 11'h012;
    @(negedge clk); y_in = '0;
    @(negedge clk);
    chk("halt no count", longint'(inst[1].dc), 1);
    chk("halt held", longint'(inst[1].dut.state), 2);
    chk("halt no capture", longint'(inst[1].lvl), 0);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("clr state idle", longint'(inst[1].dut.state), 0);
    chk("clr drop_cnt", longint'(inst[1].dc), 0);
    @(negedge clk);
    chk("resume state run", longint'(inst[1].dut.state), 1);
    y_in = 11'h033;
    @(negedge clk); y_in = '0;
    @(negedge clk);
    chk("resume level", longint'(inst[1].lvl), 1);
    chk("resume y", longint'(inst[1].rdd[10:0]), 'h033);

    // Timestamp wrap on the 4-bit instance.
    rd_ready = 1'b1;
    repeat (12) @(negedge clk);
    rd_ready = 1'b0;
    for (int n = 0; n < 16 && (cyc % 16) != 15; n++) @(negedge clk);
    y_in = 11'h001;
    @(negedge clk); y_in = 11'h002;
    @(negedge clk); y_in = '0;
    @(negedge clk);
    chk("wrap level", longint'(inst[2].lvl), 2);
    chk("wrap ts first", longint'(inst[2].rdd[14:11]), 'hF);
    chk("wrap y first", longint'(inst[2].rdd[10:0]), 1);
    rd_ready = 1'b1;
    @(negedge clk); rd_ready = 1'b0;
    chk("wrap ts second", longint'(inst[2].rdd[14:11]), 0);
    chk("wrap y second", longint'(inst[2].rdd[10:0]), 2);

    // Reset with five entries queued and the consumer ready.
    rd_ready = 1'b1;
    repeat (10) @(negedge clk);
    rd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      y_in = 11'h100 + 11'(i);
      @(negedge clk);
    end
    y_in = '0;
    @(negedge clk);
    chk("pre-reset level", longint'(inst[0].lvl), 5);
    rst = 1'b1; rd_ready = 1'b1;
    @(negedge clk);
    chk("mid reset level", longint'(inst[0].lvl), 0);
    chk("mid reset rd_valid", longint'(inst[0].rdv), 0);
    chk("mid reset drop_cnt", longint'(inst[0].dc), 0);
    chk("mid reset rd_data", longint'(inst[0].rdd), 0);
    rst = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
